// File: rtl/gcm_tag_gate.sv
// gcm_tag_gate: receive-side release-after-verify gate for the GCM-AES output
// stream. Output blocks are buffered until the computed tag has been compared
// with the host's expected tag. On a match they are released downstream. On a
// mismatch or an overflow they are discarded.
module gcm_tag_gate #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_cp_ready,
    input  logic [0:127] i_cipher_text,
    input  logic         i_tag_ready,
    input  logic [0:127] i_tag,
    input  logic         i_exp_tag_valid,
    input  logic [0:127] i_exp_tag,
    output logic         o_block_valid,
    output logic [0:127] o_block,
    input  logic         i_block_ready,
    output logic         o_done,
    output logic         o_auth_ok,
    output logic         o_auth_fail,
    output logic         o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [1:0] {COLLECT, COMPARE, RELEASE, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [0:127]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [0:127]  tag_q, exp_q;
    logic          tag_vld_q, exp_vld_q, ovf_q;
    logic          drop_q, done_q, ok_q, fail_q;

    // Decoded per-cycle controls
    logic blk_vld, pop, retire, retire_ok, push, full, in_collect;

    assign in_collect = (state_q == COLLECT);
    assign full       = (cnt_q == FULL_CNT);
    // The pipeline cannot stall, so a block arriving while full is simply lost.
    assign push       = in_collect && i_cp_ready && !full;
    assign pop        = blk_vld && i_block_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    // Next-state: leave RELEASE once the last buffered block is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (tag_vld_q && exp_vld_q) state_d = COMPARE;
            COMPARE: state_d = ((tag_q == exp_q) && !ovf_q) ? RELEASE : FLUSH;
            RELEASE: if ((cnt_q == '0) || ((cnt_q == ONE_CNT) && i_block_ready))
                         state_d = COLLECT;
            FLUSH:   state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output decode. The retire condition is computed from registered state
    // here, not from state_d, so the two combinational processes stay independent.
    always_comb begin
        blk_vld   = 1'b0;
        retire    = 1'b0;
        retire_ok = 1'b0;
        case (state_q)
            RELEASE: begin
                blk_vld   = (cnt_q != '0);
                retire    = (cnt_q == '0) || ((cnt_q == ONE_CNT) && i_block_ready);
                retire_ok = retire;
            end
            FLUSH:   retire = 1'b1;
            default: ;
        endcase
    end

    // FIFO storage. It is not reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= i_cipher_text;
    end

    // FIFO pointers, tag holders, overflow/drop tracking and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            exp_q     <= '0;
            tag_vld_q <= 1'b0;
            exp_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            done_q <= retire;
            ok_q   <= retire_ok;
            fail_q <= retire && !retire_ok;

            if (push) begin
                wr_q  <= wr_q + AW'(1);
                cnt_q <= cnt_q + ONE_CNT;
            end
            if (in_collect && i_cp_ready && full) begin
                ovf_q  <= 1'b1;
                drop_q <= 1'b1;
            end
            if (pop) begin
                rd_q  <= rd_q + AW'(1);
                cnt_q <= cnt_q - ONE_CNT;
            end
            if (state_q == FLUSH) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end

            if (in_collect && i_tag_ready) begin
                tag_q     <= i_tag;
                tag_vld_q <= 1'b1;
            end
            // Upstream traffic outside COLLECT belongs to no instance and is lost.
            if (!in_collect && (i_cp_ready || i_tag_ready)) drop_q <= 1'b1;

            if (i_exp_tag_valid && !exp_vld_q && (state_q != FLUSH)) begin
                exp_q     <= i_exp_tag;
                exp_vld_q <= 1'b1;
            end

            if (retire) begin
                tag_vld_q <= 1'b0;
                exp_vld_q <= 1'b0;
                ovf_q     <= 1'b0;
            end
        end
    end

    assign o_block_valid = blk_vld;
    assign o_block       = blk_vld ? mem_q[rd_q] : '0;
    assign o_done        = done_q;
    assign o_auth_ok     = ok_q;
    assign o_auth_fail   = fail_q;
    assign o_drop        = drop_q;

endmodule

// File: tb/tb_gcm_tag_gate.sv
// Self-checking bench for gcm_tag_gate. A queue-based model says, for each
// instance, which blocks must appear and when the instance must retire.
module tb_gcm_tag_gate;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_cp_ready, i_tag_ready, i_exp_tag_valid, i_block_ready;
    logic [0:127] i_cipher_text, i_tag, i_exp_tag;
    logic         o_block_valid, o_done, o_auth_ok, o_auth_fail, o_drop;
    logic [0:127] o_block;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit exp_drop = 1'b0;

    gcm_tag_gate #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_cp_ready(i_cp_ready), .i_cipher_text(i_cipher_text),
        .i_tag_ready(i_tag_ready), .i_tag(i_tag),
        .i_exp_tag_valid(i_exp_tag_valid), .i_exp_tag(i_exp_tag),
        .o_block_valid(o_block_valid), .o_block(o_block),
        .i_block_ready(i_block_ready),
        .o_done(o_done), .o_auth_ok(o_auth_ok), .o_auth_fail(o_auth_fail),
        .o_drop(o_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle();
        i_cp_ready = 0; i_tag_ready = 0; i_exp_tag_valid = 0; i_block_ready = 0;
        i_cipher_text = '0; i_tag = '0; i_exp_tag = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        checks++; if (o_block_valid !== 1'b0) begin errors++; $display("FAIL %s valid: got %b want 0", name, o_block_valid); end
        checks++; if (o_block !== 128'd0) begin errors++; $display("FAIL %s block: got %h want 0", name, o_block); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", name, o_done); end
        checks++; if (o_auth_ok !== 1'b0) begin errors++; $display("FAIL %s ok: got %b want 0", name, o_auth_ok); end
        checks++; if (o_auth_fail !== 1'b0) begin errors++; $display("FAIL %s fail: got %b want 0", name, o_auth_fail); end
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL %s drop: got %b want 0", name, o_drop); end
    endtask

    // One instance: n blocks in consecutive cycles with the tag on the last
    // one. exp_dly < 0 sends the expected tag in the first cycle, otherwise
    // exp_dly cycles after the tag. rmode: 0 always ready, 1 pattern 1,0,0,1,
    // 2 random. viol injects upstream traffic during release.
    task automatic run_inst(input string name, input int n, input bit seq, input bit match,
                            input int exp_dly, input int rmode, input bit viol,
                            input logic [0:127] tagv);
        logic [0:127] q[$];
        logic [0:127] got[$];
        logic [0:127] expt, prev_b;
        int tc, tedge, eedge, e, first_v, last_hs, done_c, exp_done;
        bit seen, g_ok, g_fail, prev_v, prev_r, rdy, vdone, pass;
        int pat[4] = '{1, 0, 0, 1};
        for (int i = 0; i < n; i++)
            q.push_back(seq ? 128'(i + 1) : {$urandom(), $urandom(), $urandom(), $urandom()});
        expt = match ? tagv : (tagv ^ 128'd1);
        tc = (n > 0) ? n - 1 : 0;
        tedge = -1; eedge = -1; first_v = -1; last_hs = -1; done_c = -1;
        seen = 0; g_ok = 0; g_fail = 0; prev_v = 0; prev_r = 0; prev_b = '0; vdone = 0;
        for (int c = 0; c < 4 * n + exp_dly + 60; c++) begin
            if (prev_v && !prev_r) begin
                checks++;
                if (!(o_block_valid === 1'b1 && o_block === prev_b)) begin
                    errors++; $display("FAIL %s hold: got v=%b %h want v=1 %h", name, o_block_valid, o_block, prev_b);
                end
            end
            if (o_block_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (o_done === 1'b1) begin
                seen = 1; done_c = cyc; g_ok = o_auth_ok; g_fail = o_auth_fail;
                idle();
                break;
            end
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[c % 4] != 0 : 1'($urandom_range(0, 1));
            i_block_ready = rdy;
            if (o_block_valid === 1'b1 && rdy) begin got.push_back(o_block); last_hs = cyc; end
            prev_v = (o_block_valid === 1'b1); prev_r = rdy; prev_b = o_block;
            i_cp_ready = (c < n);
            i_cipher_text = (c < n) ? q[c] : '0;
            if (c < n && c >= DEPTH) exp_drop = 1'b1;
            i_tag_ready = (c == tc); i_tag = tagv;
            if (c == tc) tedge = cyc + 1;
            i_exp_tag_valid = (exp_dly < 0) ? (c == 0) : (c == tc + exp_dly);
            i_exp_tag = expt;
            if (i_exp_tag_valid && eedge < 0) eedge = cyc + 1;
            if (viol && !vdone && o_block_valid === 1'b1) begin
                i_cp_ready = 1; i_cipher_text = {$urandom(), $urandom(), $urandom(), $urandom()};
                i_tag_ready = 1; vdone = 1; exp_drop = 1'b1;
            end
            step();
        end
        idle();
        pass = match && (n <= DEPTH);
        e = (tedge > eedge) ? tedge : eedge;
        checks++;
        if (!seen) begin errors++; $display("FAIL %s timeout: got no done want done", name); end
        else begin
            checks++;
            if (g_ok !== pass || g_fail !== !pass) begin
                errors++; $display("FAIL %s auth: got ok=%b fail=%b want ok=%b", name, g_ok, g_fail, pass);
            end
            exp_done = (!pass || n == 0) ? e + 3 : last_hs + 1;
            checks++;
            if (done_c != exp_done) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, exp_done); end
        end
        if (pass) begin
            checks++;
            if (got.size() != n) begin errors++; $display("FAIL %s count: got %0d want %0d", name, got.size(), n); end
            for (int i = 0; i < n && i < got.size(); i++) begin
                checks++;
                if (got[i] !== q[i]) begin errors++; $display("FAIL %s blk%0d: got %h want %h", name, i, got[i], q[i]); end
            end
            if (n > 0) begin
                checks++;
                if (first_v != e + 2) begin errors++; $display("FAIL %s first_valid: got %0d want %0d", name, first_v, e + 2); end
                if (rmode == 0) begin
                    checks++;
                    if (last_hs != e + 1 + n) begin errors++; $display("FAIL %s last_hs: got %0d want %0d", name, last_hs, e + 1 + n); end
                end
            end
        end else begin
            checks++;
            if (first_v != -1 || got.size() != 0) begin
                errors++; $display("FAIL %s leak: got valid at %0d, %0d blocks want none", name, first_v, got.size());
            end
        end
        checks++;
        if (o_drop !== exp_drop) begin errors++; $display("FAIL %s drop: got %b want %b", name, o_drop, exp_drop); end
        step();
        checks++;
        if (o_done !== 1'b0 || o_auth_ok !== 1'b0 || o_auth_fail !== 1'b0) begin
            errors++; $display("FAIL %s pulse_width: got done=%b ok=%b fail=%b want 0", name, o_done, o_auth_ok, o_auth_fail);
        end
    endtask

    task automatic test_reset();
        rst = 1; idle();
        step(); step();
        check_zero("reset");
        rst = 0; exp_drop = 0;
        step();
        check_zero("reset_release");
    endtask

    task automatic test_match();
        run_inst("match", 3, 1, 1, -1, 0, 0, 128'hFEEDFACE_00000000_00000000_0000CAFE);
    endtask

    task automatic test_mismatch();
        run_inst("mismatch", 3, 1, 0, -1, 0, 0, 128'hFEEDFACE_00000000_00000000_0000CAFE);
        run_inst("after_mismatch", 2, 0, 1, 0, 0, 0, 128'h1234);
    endtask

    task automatic test_backpressure();
        run_inst("backpressure", 4, 0, 1, -1, 1, 0, 128'hA5A5);
    endtask

    task automatic test_late_exp_zero();
        run_inst("late_exp_zero", 0, 0, 1, 5, 0, 0, 128'hBEEF_0001);
    endtask

    task automatic test_violation();
        run_inst("violation", 3, 0, 1, 0, 0, 1, 128'h77);
    endtask

    task automatic test_overflow();
        run_inst("overflow", 17, 0, 1, -1, 0, 0, 128'hFEEDFACE_00000000_00000000_0000CAFE);
        run_inst("after_overflow", 16, 0, 1, -1, 2, 0, 128'h5A);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++)
            run_inst("random", $urandom_range(0, DEPTH + 2), 0, $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 7)) - 1, 2, 0,
                     {$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic test_reset_mid_release();
        logic [0:127] q[$];
        logic [0:127] tagv;
        int pops;
        bit hit;
        tagv = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 8; i++) q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        pops = 0; hit = 0;
        for (int c = 0; c < 60; c++) begin
            if (pops == 2) begin
                rst = 1; idle(); hit = 1;
                step();
                check_zero("mid_reset");
                rst = 0; exp_drop = 0;
                break;
            end
            i_block_ready = 1;
            if (o_block_valid === 1'b1) begin
                checks++;
                if (o_block !== q[pops]) begin errors++; $display("FAIL mid_blk%0d: got %h want %h", pops, o_block, q[pops]); end
                pops++;
            end
            i_cp_ready = (c < 8); i_cipher_text = (c < 8) ? q[c] : '0;
            i_tag_ready = (c == 7); i_tag = tagv;
            i_exp_tag_valid = (c == 0); i_exp_tag = tagv;
            step();
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_timeout: got %0d pops want 2", pops); end
        run_inst("post_reset", 1, 0, 1, -1, 0, 0, 128'hC0FFEE);
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_backpressure();
        test_late_exp_zero();
        test_random();
        test_violation();
        test_reset();
        test_overflow();
        test_reset();
        test_reset_mid_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcm_tag_gate.md
# gcm_tag_gate

Receive-side gate for the GCM-AES pipeline output stream. Collects the per-instance 128-bit output blocks (`cp_ready`/`cipher_text`) and the computed tag (`tag_ready`/`tag`) into an on-chip FIFO. Compares the computed tag against an expected tag supplied by the host. Releases the buffered blocks downstream under valid/ready flow control only on a match, and discards them on a mismatch (release-after-verify). It sits directly after the pipeline's final stage, which cannot stall.

## Interface
- `DEPTH`, default 16: FIFO capacity in 128-bit blocks. Must be a power of 2, at least 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_cp_ready`  in  1  output block from the pipeline is valid this cycle. No backpressure is possible.
- `i_cipher_text`  in  [0:127]  pipeline output block.
- `i_tag_ready`  in  1  computed tag valid; marks the end of an instance.
- `i_tag`  in  [0:127]  computed tag.
- `i_exp_tag_valid`  in  1  expected tag strobe from the host.
- `i_exp_tag`  in  [0:127]  expected tag.
- `o_block_valid`  out  1  released block available.
- `o_block`  out  [0:127]  released block (FIFO head, first-word-fall-through).
- `i_block_ready`  in  1  downstream accepts `o_block`.
- `o_done`  out  1  one-cycle pulse when an instance is retired.
- `o_auth_ok`  out  1  one-cycle pulse with `o_done`, on a match.
- `o_auth_fail`  out  1  one-cycle pulse with `o_done`, on a mismatch or overflow.
- `o_drop`  out  1  sticky flag: a block or tag was lost. Cleared only by `rst`.

## Operation
- **States:** COLLECT, COMPARE, RELEASE, FLUSH. The state resets to COLLECT.
- **COLLECT:**
  - `i_cp_ready`=1 writes `i_cipher_text` to the FIFO and increments the count.
  - `i_tag_ready`=1 latches `i_tag`. If `i_cp_ready` is also 1 in that cycle, that block is written and counts as part of the instance.
  - After the tag is latched, the block moves to COMPARE in the first cycle in which an expected tag is also latched.
- **Expected tag:**
  - `i_exp_tag_valid` latches `i_exp_tag` in COLLECT, COMPARE, or RELEASE only when no expected tag is currently held. Otherwise the strobe is ignored.
  - The strobe may precede, coincide with, or follow `i_tag_ready`.
  - The expected-tag holder is cleared when the instance retires.
- **COMPARE:**
  - Evaluates a full 128-bit equality.
  - Match with no overflow this instance → RELEASE.
  - Otherwise → FLUSH.
- **RELEASE:**
  - `o_block_valid` = FIFO not empty.
  - A pop occurs on `o_block_valid` & `i_block_ready`.
  - When the FIFO is empty (immediately, for a zero-block instance), the block returns to COLLECT and pulses `o_done` and `o_auth_ok`.
- **FLUSH:**
  - Resets the FIFO pointers and count in one cycle.
  - Returns to COLLECT and pulses `o_done` and `o_auth_fail`.
- **Overflow:**
  - A write with count == DEPTH drops the block and sets `o_drop`.
  - It also marks the instance failed, so the tag result is ignored.
- **Protocol violations:**
  - `i_cp_ready` or `i_tag_ready` outside COLLECT drops the data and sets `o_drop`. It does not affect the current instance.
  - Upstream must not start the next instance before `o_done`.
- **Pointers:** log2(DEPTH) bits wide with wrap-around. The count is log2(DEPTH)+1 bits wide.

## Timing
- **Reset values:** all outputs 0, FIFO empty, no tags held, state COLLECT.
- **Reset mid-operation:** takes effect on the next edge and discards all buffered blocks and tags, in any state.
- **Match path:** tag latched at edge T (expected tag already held) → COMPARE in cycle T+1 → RELEASE in T+2, with the first `o_block_valid` in T+2.
- **Late expected tag:** if the expected tag arrives at edge E > T, COMPARE occurs in cycle E+1.
- **Release throughput:** one block per cycle while `i_block_ready`=1.
- **Completion:** after the last handshake in cycle R, `o_done`/`o_auth_ok` are high in cycle R+1, with state COLLECT.
- **Zero-block instance:** `o_done` in T+3.
- **Mismatch path:** FLUSH in T+2; `o_done`/`o_auth_fail` in T+3.
- **Next instance:** a new instance may begin writing in the same cycle `o_done` is high.
- **Output stability:** `o_block` is stable while `o_block_valid`=1 and `i_block_ready`=0.

## Test plan
- **Match, back-to-back:** 3 blocks 0x..01, 0x..02, 0x..03 in consecutive cycles; tag and expected tag both 0xFEEDFACE_00000000_00000000_0000CAFE; `i_block_ready`=1. Required: blocks out in order in cycles T+2..T+4, `o_done`+`o_auth_ok` in T+5.
- **Mismatch:** same stimulus with the expected tag LSB flipped. Required: `o_block_valid` never asserts, `o_done`+`o_auth_fail` in T+3, FIFO empty afterwards.
- **Backpressure:** 4 blocks, with `i_block_ready` toggling 1,0,0,1,…. Required: `o_block` holds during stalls, all 4 blocks delivered in order, `o_done` one cycle after the 4th handshake.
- **Overflow:** DEPTH=16, 17 blocks with matching tags. Required: `o_drop`=1 after the 17th block, `o_auth_fail` pulse, no blocks released.
- **Late expected tag and zero blocks:**
  - Tag with no blocks; expected tag equal, 5 cycles later at edge E. Required: `o_done`+`o_auth_ok` in E+3.
  - Then assert `i_cp_ready` during RELEASE of a later instance. Required: `o_drop`=1.
- **Reset mid-release:** 8 blocks matched, `rst` after 2 pops. Required: all outputs 0 the next cycle; a following 1-block matched instance releases correctly.
